// File: rtl/mem_data_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Holds the funct3 access codes, FSM states and the access-legality check.
package mem_data_lsu_pkg;

  localparam int XLEN       = 32;
  localparam int ADDRESSLEN = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // Misaligned halves/words, unsigned stores and unused codes are all faults.
  function automatic logic lsuFault(input logic write, input logic [2:0] funct3,
                                    input logic [1:0] lane);
    logic f;
    case (funct3)
      LSU_B:   f = 1'b0;
      LSU_BU:  f = write;
      LSU_H:   f = lane[0];
      LSU_HU:  f = lane[0] | write;
      LSU_W:   f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_data_lsu_if.sv
// Request/response handshake plus word-memory port bundle for the LSU.
// master = core MEM stage, slave = LSU, memory = memData responder.
interface mem_data_lsu_if;
  import mem_data_lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDRESSLEN-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_rdata;
  logic                  resp_fault;
  logic [ADDRESSLEN-1:0] mem_readAddress;
  logic [ADDRESSLEN-1:0] mem_writeAddress;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_readEnabled;
  logic                  mem_writeEnabled;
  logic [XLEN-1:0]       mem_out;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_readAddress, mem_writeAddress, mem_data, mem_readEnabled, mem_writeEnabled
  );

  modport memory (
    input  mem_readAddress, mem_writeAddress, mem_data, mem_readEnabled, mem_writeEnabled,
    output mem_out
  );

endinterface

// File: rtl/mem_data_lsu_align.sv
// Byte-lane steering: extends sub-word loads and merges sub-word stores
// into a full memory word.
module mem_data_lsu_align
  import mem_data_lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] store_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word_i[8*lane_i +: 8];
    halfSel = word_i[16*lane_i[1] +: 16];

    case (funct3_i)
      LSU_B:   load_o = {{24{byteSel[7]}}, byteSel};
      LSU_BU:  load_o = {24'h0, byteSel};
      LSU_H:   load_o = {{16{halfSel[15]}}, halfSel};
      LSU_HU:  load_o = {16'h0, halfSel};
      default: load_o = word_i;
    endcase

    // Untouched lanes keep the word read back in the RD cycle.
    store_o = word_i;
    case (funct3_i)
      LSU_B:   store_o[8*lane_i +: 8]      = wdata_i[7:0];
      LSU_H:   store_o[16*lane_i[1] +: 16] = wdata_i[15:0];
      LSU_W:   store_o                     = wdata_i;
      default: store_o                     = word_i;
    endcase
  end

endmodule

// File: rtl/mem_data_lsu.sv
// Load/store initiator between the MEM stage and the word-addressed data memory.
// One request in flight; sub-word stores go through a read-modify-write.
module mem_data_lsu
  import mem_data_lsu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mem_data_lsu_if.slave  bus
);

  lsu_state_e            state_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDRESSLEN-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       word_q;
  logic                  readEn_q;
  logic                  writeEn_q;
  logic                  respValid_q;
  logic                  respFault_q;
  logic [XLEN-1:0]       respRdata_q;

  logic                  acceptReq;
  logic                  reqFault;
  logic [XLEN-1:0]       alignWord;
  logic [XLEN-1:0]       loadData;
  logic [XLEN-1:0]       storeWord;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign acceptReq     = bus.req_valid && bus.req_ready;
  assign reqFault      = lsuFault(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  // Loads extract straight from the memory word; stores merge into the captured copy.
  assign alignWord = (state_q == RD) ? bus.mem_out : word_q;

  mem_data_lsu_align u_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (alignWord),
    .wdata_i  (wdata_q),
    .load_o   (loadData),
    .store_o  (storeWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      readEn_q    <= 1'b0;
      writeEn_q   <= 1'b0;
      respValid_q <= 1'b0;
      respFault_q <= 1'b0;
      respRdata_q <= '0;
    end else begin
      respValid_q <= 1'b0;
      readEn_q    <= 1'b0;
      writeEn_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acceptReq) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (reqFault) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respFault_q <= 1'b1;
              respRdata_q <= '0;
            end else if (bus.req_write && bus.req_funct3 == LSU_W) begin
              state_q   <= WR;
              writeEn_q <= 1'b1;
            end else begin
              state_q  <= RD;
              readEn_q <= 1'b1;
            end
          end
        end
        RD: begin
          word_q <= bus.mem_out;
          if (write_q) begin
            state_q   <= WR;
            writeEn_q <= 1'b1;
          end else begin
            state_q     <= RESP;
            respValid_q <= 1'b1;
            respFault_q <= 1'b0;
            respRdata_q <= loadData;
          end
        end
        WR: begin
          state_q     <= RESP;
          respValid_q <= 1'b1;
          respFault_q <= 1'b0;
          respRdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid       = respValid_q;
  assign bus.resp_rdata       = respRdata_q;
  assign bus.resp_fault       = respFault_q;
  assign bus.mem_readAddress  = {addr_q[ADDRESSLEN-1:2], 2'b00};
  assign bus.mem_writeAddress = {addr_q[ADDRESSLEN-1:2], 2'b00};
  assign bus.mem_data         = storeWord;
  assign bus.mem_readEnabled  = readEn_q && !reset;
  assign bus.mem_writeEnabled = writeEn_q && !reset;

endmodule

// File: tb/tb_mem_data_lsu.sv
// Randomized and directed bench for mem_data_lsu against a byte-array memory model.
// The bench also plays the memData responder (negedge read, posedge write).
module tb_mem_data_lsu;
  import mem_data_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_data_lsu_if bus();

  mem_data_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] memWords [0:63];
  logic [7:0]  refBytes [0:255];
  int compared   = 0;
  int mismatched = 0;

  always @(negedge clk)
    if (bus.mem_readEnabled) bus.mem_out <= memWords[bus.mem_readAddress[7:2]];

  always @(posedge clk)
    if (bus.mem_writeEnabled) memWords[bus.mem_writeAddress[7:2]] <= bus.mem_data;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic modelFault(input logic w, input logic [2:0] f3, input int a);
    logic legal;
    legal = (f3 == 3'd0 || f3 == 3'd4) ||
            ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 == 0)) ||
            (f3 == 3'd2 && (a % 4 == 0));
    if (w && f3 >= 3'd4) legal = 1'b0;
    return !legal;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int a);
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] r;
    b0 = refBytes[a];
    b1 = (f3 == 3'd0 || f3 == 3'd4) ? 8'h00 : refBytes[a+1];
    b2 = (f3 == 3'd2) ? refBytes[a+2] : 8'h00;
    b3 = (f3 == 3'd2) ? refBytes[a+3] : 8'h00;
    case (f3)
      3'd0:    r = {{24{b0[7]}}, b0};
      3'd4:    r = {24'h0, b0};
      3'd1:    r = {{16{b1[7]}}, b1, b0};
      3'd5:    r = {16'h0, b1, b0};
      3'd2:    r = {b3, b2, b1, b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic modelStore(input logic [2:0] f3, input int a, input logic [31:0] d);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) refBytes[a+i] = d[8*i +: 8];
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("%s/word%0d", tag, i), memWords[i],
                  {refBytes[4*i+3], refBytes[4*i+2], refBytes[4*i+1], refBytes[4*i]});
  endtask

  // One transaction: returns latency (cycles after accept), response and memory activity.
  task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, output int lat, output logic [31:0] rdata,
                               output logic fault, output int rdCnt, output int wrCnt,
                               output logic pulseAfter, output logic readyAfter);
    int waited;
    lat = -1; rdata = 32'hX; fault = 1'bX; rdCnt = 0; wrCnt = 0;
    pulseAfter = 1'bX; readyAfter = 1'bX;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    waited = 0;
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      rdCnt += int'(bus.mem_readEnabled);
      wrCnt += int'(bus.mem_writeEnabled);
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; fault = bus.resp_fault;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    pulseAfter = bus.resp_valid;
    readyAfter = bus.req_ready;
  endtask

  task automatic runTxn(input string tag, input logic w, input logic [2:0] f3, input int a,
                        input logic [31:0] d, output logic [31:0] rdataOut);
    logic expFault, fault, pulseAfter, readyAfter;
    logic [31:0] expData, rdata;
    int expLat, lat, rdCnt, wrCnt, expRd, expWr;
    expFault = modelFault(w, f3, a);
    expData  = (expFault || w) ? 32'h0 : modelLoad(f3, a);
    if (expFault)            begin expLat = 1; expRd = 0; expWr = 0; end
    else if (!w)             begin expLat = 2; expRd = 1; expWr = 0; end
    else if (f3 == 3'd2)     begin expLat = 2; expRd = 0; expWr = 1; end
    else                     begin expLat = 3; expRd = 1; expWr = 1; end
    applyStimulus(w, f3, a, d, lat, rdata, fault, rdCnt, wrCnt, pulseAfter, readyAfter);
    checkOutput({tag, "/latency"}, lat, expLat);
    checkOutput({tag, "/fault"}, {31'h0, fault}, {31'h0, expFault});
    checkOutput({tag, "/rdata"}, rdata, expData);
    checkOutput({tag, "/rdCycles"}, rdCnt, expRd);
    checkOutput({tag, "/wrCycles"}, wrCnt, expWr);
    checkOutput({tag, "/pulseWidth"}, {31'h0, pulseAfter}, 32'h0);
    checkOutput({tag, "/readyAfter"}, {31'h0, readyAfter}, 32'h1);
    if (!expFault && w) modelStore(f3, a, d);
    rdataOut = rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] snapWord;
  int accepts, pulses, busyReady, cyc, extraPulses, lateWrites, lateResp;
  logic [31:0] burstData [0:3];

  initial begin
    for (int i = 0; i < 64; i++) begin
      memWords[i] = $urandom;
      for (int j = 0; j < 4; j++) refBytes[4*i+j] = memWords[i][8*j +: 8];
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset with a request pending: must be ignored.
    reset = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    checkOutput("rst/ready", {31'h0, bus.req_ready}, 32'h0);
    checkOutput("rst/respValid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("rst/memEn", {30'h0, bus.mem_readEnabled, bus.mem_writeEnabled}, 32'h0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst/readyAfter", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("rst/rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst/fault", {31'h0, bus.resp_fault}, 32'h0);
    checkMemory("rst/mem");

    // Directed word, byte and half accesses.
    runTxn("sw8", 1'b1, 3'd2, 8, 32'hDEADBEEF, rd);
    runTxn("lw8", 1'b0, 3'd2, 8, 32'h0, rd);
    checkOutput("lw8/const", rd, 32'hDEADBEEF);
    runTxn("sb9", 1'b1, 3'd0, 9, 32'h0000007F, rd);
    checkOutput("sb9/word", memWords[2], 32'hDEAD7FEF);
    runTxn("lbB", 1'b0, 3'd0, 11, 32'h0, rd);
    checkOutput("lbB/const", rd, 32'hFFFFFFDE);
    runTxn("lbuB", 1'b0, 3'd4, 11, 32'h0, rd);
    checkOutput("lbuB/const", rd, 32'h000000DE);
    runTxn("shA", 1'b1, 3'd1, 10, 32'h00008001, rd);
    checkOutput("shA/word", memWords[2], 32'h80017FEF);
    runTxn("lhA", 1'b0, 3'd1, 10, 32'h0, rd);
    checkOutput("lhA/const", rd, 32'hFFFF8001);
    runTxn("lhuA", 1'b0, 3'd5, 10, 32'h0, rd);
    checkOutput("lhuA/const", rd, 32'h00008001);

    // Faults: misaligned word, misaligned half store, illegal funct3, unsigned store.
    runTxn("lw6", 1'b0, 3'd2, 6, 32'h0, rd);
    runTxn("sh3", 1'b1, 3'd1, 3, 32'h0000BEEF, rd);
    runTxn("f011", 1'b0, 3'd3, 16, 32'h0, rd);
    runTxn("sbu", 1'b1, 3'd4, 20, 32'h000000AA, rd);
    checkMemory("fault/mem");

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      runTxn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 252)), $urandom, rd);
    end
    checkMemory("rnd/mem");

    // Back-to-back SW with req_valid held high.
    for (int i = 0; i < 4; i++) burstData[i] = $urandom;
    accepts = 0; pulses = 0; busyReady = 0; cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h80; bus.req_wdata = burstData[0];
    while (cyc < 60 && (accepts < 4 || pulses < 4)) begin
      if (bus.resp_valid) pulses++;
      if (bus.req_valid && bus.req_ready) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        modelStore(3'd2, int'(bus.req_addr), bus.req_wdata);
        accepts++;
        if (bus.req_ready) busyReady++;
        if (accepts < 4) begin
          bus.req_addr = 32'h80 + 32'(4 * accepts);
          bus.req_wdata = burstData[accepts];
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    extraPulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) extraPulses++;
    end
    checkOutput("burst/accepts", accepts, 4);
    checkOutput("burst/pulses", pulses + extraPulses, 4);
    checkOutput("burst/busyReady", busyReady, 0);
    checkMemory("burst/mem");

    // Reset during the RD cycle of a byte store.
    snapWord = memWords[12];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h31; bus.req_wdata = 32'h000000A5;
    checkOutput("abort/readyAccept", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("abort/rdCycle", {31'h0, bus.mem_readEnabled}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("abort/rdGated", {31'h0, bus.mem_readEnabled}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort/idle", {31'h0, bus.req_ready}, 32'h1);
    lateWrites = 0; lateResp = 0;
    repeat (4) begin
      if (bus.mem_writeEnabled) lateWrites++;
      if (bus.resp_valid) lateResp++;
      @(negedge clk);
    end
    checkOutput("abort/noWrite", lateWrites, 0);
    checkOutput("abort/noResp", lateResp, 0);
    checkOutput("abort/word", memWords[12], snapWord);
    checkMemory("abort/mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
